stopwatch_controller: RTL and testbench

STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

---
 rtl/stopwatch_controller.sv | 141 ++++++++++++++
 tb/tb_stopwatch_controller.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_controller.sv
// Stopwatch mode controller: run/stop, digit edit walk with blink and inactivity timeout.
// Latency: every output is registered, one clock after the qualifying input pulse.
// Backpressure: none; the one-cycle button pulses are consumed on the edge they are sampled.
module stopwatch_controller #(
  parameter int PULSE_MAX    = 999999,
  parameter int BLINK_TICKS  = 50,
  parameter int EDIT_TIMEOUT = 1000
) (
  input  logic       clk100_i,
  input  logic       rstn_i,
  input  logic       start_stop_pulse_i,
  input  logic       set_pulse_i,
  input  logic       change_pulse_i,
  output logic       running_o,
  output logic       tick_o,
  output logic [2:0] state_o,
  output logic [3:0] digit_inc_o,
  output logic       clear_o,
  output logic [3:0] blank_o
);

  localparam int PW = $clog2(PULSE_MAX + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam int TW = $clog2(EDIT_TIMEOUT + 1);

  localparam logic [PW-1:0] PMAX  = PW'(PULSE_MAX);
  localparam logic [BW-1:0] BLAST = BW'(BLINK_TICKS - 1);
  localparam logic [TW-1:0] TMAX  = TW'(EDIT_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EDIT0 = 3'd1,
    EDIT1 = 3'd2,
    EDIT2 = 3'd3,
    EDIT3 = 3'd4
  } state_t;

  state_t        state, nxt_state;
  logic [PW-1:0] run_cnt, base_cnt;
  logic [BW-1:0] blink_cnt, nxt_blink_cnt;
  logic [TW-1:0] idle_cnt, nxt_idle_cnt;
  logic          blink_phase, nxt_blink_phase;
  logic          nxt_running, nxt_clear;
  logic [3:0]    nxt_inc, nxt_blank;
  logic          base_tick;

  // One-hot digit addressed by an edit state; zero in IDLE.
  function automatic logic [3:0] digit_sel(input state_t s);
    case (s)
      EDIT0:   digit_sel = 4'b0001;
      EDIT1:   digit_sel = 4'b0010;
      EDIT2:   digit_sel = 4'b0100;
      EDIT3:   digit_sel = 4'b1000;
      default: digit_sel = 4'b0000;
    endcase
  endfunction

  assign base_tick = (base_cnt == PMAX);
  assign state_o   = state;

  // Next-state decode: start_stop beats set beats change; timeout sits between set and change.
  always_comb begin
    nxt_state       = state;
    nxt_running     = running_o;
    nxt_inc         = 4'b0000;
    nxt_clear       = 1'b0;
    nxt_blink_phase = blink_phase;
    nxt_blink_cnt   = blink_cnt;
    nxt_idle_cnt    = idle_cnt;
    if (state == IDLE) begin
      nxt_blink_phase = 1'b0;
      nxt_blink_cnt   = '0;
      nxt_idle_cnt    = '0;
      if (start_stop_pulse_i) begin
        nxt_running = ~running_o;
      end else if (set_pulse_i) begin
        if (!running_o) nxt_state = EDIT0;
      end else if (change_pulse_i) begin
        if (!running_o) nxt_clear = 1'b1;
      end
    end else begin
      nxt_running = 1'b0;
      if (set_pulse_i) begin
        nxt_state       = (state == EDIT3) ? IDLE : state_t'(state + 3'd1);
        nxt_blink_phase = 1'b0;
        nxt_blink_cnt   = '0;
        nxt_idle_cnt    = '0;
      end else if (idle_cnt == TMAX) begin
        nxt_state       = IDLE;
        nxt_blink_phase = 1'b0;
        nxt_blink_cnt   = '0;
        nxt_idle_cnt    = '0;
      end else if (change_pulse_i) begin
        nxt_inc         = digit_sel(state);
        nxt_blink_phase = 1'b0;
        nxt_blink_cnt   = '0;
        nxt_idle_cnt    = '0;
      end else if (base_tick) begin
        if (idle_cnt != TMAX) nxt_idle_cnt = idle_cnt + TW'(1);
        if (blink_cnt == BLAST) begin
          nxt_blink_cnt   = '0;
          nxt_blink_phase = ~blink_phase;
        end else begin
          nxt_blink_cnt = blink_cnt + BW'(1);
        end
      end
    end
    nxt_blank = nxt_blink_phase ? digit_sel(nxt_state) : 4'b0000;
  end

  // All state, prescalers and registered outputs; async reset clears everything.
  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      running_o   <= 1'b0;
      tick_o      <= 1'b0;
      digit_inc_o <= 4'b0000;
      clear_o     <= 1'b0;
      blank_o     <= 4'b0000;
      run_cnt     <= '0;
      base_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      state       <= nxt_state;
      running_o   <= nxt_running;
      digit_inc_o <= nxt_inc;
      clear_o     <= nxt_clear;
      blank_o     <= nxt_blank;
      blink_cnt   <= nxt_blink_cnt;
      blink_phase <= nxt_blink_phase;
      idle_cnt    <= nxt_idle_cnt;
      // Run prescaler holds its count while stopped so a restart resumes mid-period.
      tick_o <= running_o && (run_cnt == PMAX);
      if (running_o) run_cnt <= (run_cnt == PMAX) ? '0 : run_cnt + PW'(1);
      base_cnt <= base_tick ? '0 : base_cnt + PW'(1);
    end
  end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for stopwatch_controller with small prescaler and timeout parameters.
// Digit increment and clear strobes are checked against a queue of expected strobes.
// Base-tick timing is tracked from a cycle count that restarts with reset.
module tb_stopwatch_controller;
  localparam int PM = 4;
  localparam int BT = 2;
  localparam int ET = 6;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ss = 1'b0, st = 1'b0, ch = 1'b0;
  logic       running, tick, clear;
  logic [2:0] state;
  logic [3:0] inc, blank;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [4:0] sb[$];
  logic [4:0] sb_exp;

  stopwatch_controller #(.PULSE_MAX(PM), .BLINK_TICKS(BT), .EDIT_TIMEOUT(ET)) dut (
    .clk100_i(clk), .rstn_i(rstn),
    .start_stop_pulse_i(ss), .set_pulse_i(st), .change_pulse_i(ch),
    .running_o(running), .tick_o(tick), .state_o(state),
    .digit_inc_o(inc), .clear_o(clear), .blank_o(blank)
  );

  always #5 clk = ~clk;

  // Edges since reset release; a base tick lands on every edge where this is a multiple of 5.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Every clear/increment strobe must match the next expected entry.
  always @(negedge clk) begin
    if (rstn && (clear || inc != 4'b0000)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL strobe_unexpected: got clear=%b inc=%b, required no strobe", clear, inc);
      end else begin
        sb_exp = sb.pop_front();
        if ({clear, inc} !== sb_exp) begin
          bad++;
          $display("FAIL strobe_value: got clear=%b inc=%b, required clear=%b inc=%b",
                   clear, inc, sb_exp[4], sb_exp[3:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic a, input logic b, input logic c);
    ss = a; st = b; ch = c;
    step();
    ss = 1'b0; st = 1'b0; ch = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({running, tick, state, inc, clear, blank} !== 14'b0) begin
      bad++; $display("FAIL reset_outputs: got %b, required all zero", {running, tick, state, inc, clear, blank});
    end
    @(negedge clk); #2; rstn = 1'b1;
    step();
    total++;
    if ({running, tick, state, inc, clear, blank} !== 14'b0) begin
      bad++; $display("FAIL release_outputs: got %b, required all zero", {running, tick, state, inc, clear, blank});
    end
  endtask

  task automatic test_run();
    pulse(1'b1, 1'b0, 1'b0);
    total++;
    if (running !== 1'b1 || tick !== 1'b0) begin
      bad++; $display("FAIL run_start: running=%b tick=%b, required 1 0", running, tick);
    end
    for (int j = 1; j <= 16; j++) begin
      step();
      total++;
      if (tick !== (j % 5 == 0)) begin
        bad++; $display("FAIL tick_period: cycle %0d tick=%b, required %b", j, tick, (j % 5 == 0));
      end
    end
    pulse(1'b1, 1'b0, 1'b0);
    total++;
    if (running !== 1'b0 || tick !== 1'b0) begin
      bad++; $display("FAIL run_stop: running=%b tick=%b, required 0 0", running, tick);
    end
    for (int j = 0; j < 7; j++) begin
      step();
      total++;
      if (running !== 1'b0 || tick !== 1'b0) begin
        bad++; $display("FAIL stopped_hold: running=%b tick=%b, required 0 0", running, tick);
      end
    end
    pulse(1'b1, 1'b0, 1'b0);
    total++;
    if (running !== 1'b1 || tick !== 1'b0) begin
      bad++; $display("FAIL run_restart: running=%b tick=%b, required 1 0", running, tick);
    end
    for (int j = 1; j <= 4; j++) begin
      step();
      total++;
      if (tick !== (j == 3)) begin
        bad++; $display("FAIL tick_resume: cycle %0d tick=%b, required %b", j, tick, (j == 3));
      end
    end
    pulse(1'b1, 1'b0, 1'b0);
    total++;
    if (running !== 1'b0) begin
      bad++; $display("FAIL run_stop2: running=%b, required 0", running);
    end
  endtask

  task automatic test_edit_walk();
    logic [3:0] m;
    pulse(1'b0, 1'b1, 1'b0);
    total++;
    if (state !== 3'd1 || blank !== 4'b0000) begin
      bad++; $display("FAIL edit_enter: state=%0d blank=%b, required 1 0000", state, blank);
    end
    for (int j = 0; j < 3; j++) begin
      sb.push_back(5'b00001);
      pulse(1'b0, 1'b0, 1'b1);
      total++;
      if (state !== 3'd1) begin
        bad++; $display("FAIL edit_change_state: state=%0d, required 1", state);
      end
    end
    pulse(1'b1, 1'b0, 1'b0);
    total++;
    if (running !== 1'b0 || state !== 3'd1) begin
      bad++; $display("FAIL edit_start_ignored: running=%b state=%0d, required 0 1", running, state);
    end
    for (int k = 1; k <= 3; k++) begin
      pulse(1'b0, 1'b1, 1'b0);
      total++;
      if (state !== 3'(k + 1)) begin
        bad++; $display("FAIL edit_advance: state=%0d, required %0d", state, k + 1);
      end
      m = 4'b0001 << k;
      sb.push_back({1'b0, m});
      pulse(1'b0, 1'b0, 1'b1);
    end
    pulse(1'b0, 1'b1, 1'b0);
    total++;
    if (state !== 3'd0 || blank !== 4'b0000 || running !== 1'b0) begin
      bad++; $display("FAIL edit_exit: state=%0d blank=%b running=%b, required 0 0000 0", state, blank, running);
    end
  endtask

  task automatic test_blink();
    int bt;
    logic [3:0] exp;
    for (int j = 0; j < 3; j++) pulse(1'b0, 1'b1, 1'b0);
    total++;
    if (state !== 3'd3 || blank !== 4'b0000) begin
      bad++; $display("FAIL blink_enter: state=%0d blank=%b, required 3 0000", state, blank);
    end
    bt = 0;
    for (int n = 0; n < 40 && bt < 3; n++) begin
      step();
      if (cyc % 5 == 0) bt++;
      exp = ((bt / 2) % 2 == 1) ? 4'b0100 : 4'b0000;
      total++;
      if (blank !== exp) begin
        bad++; $display("FAIL blink_phase: ticks=%0d blank=%b, required %b", bt, blank, exp);
      end
    end
    sb.push_back(5'b00100);
    pulse(1'b0, 1'b0, 1'b1);
    bt = 0;
    total++;
    if (blank !== 4'b0000 || state !== 3'd3) begin
      bad++; $display("FAIL blink_restart: blank=%b state=%0d, required 0000 3", blank, state);
    end
    for (int n = 0; n < 40 && bt < 4; n++) begin
      step();
      if (cyc % 5 == 0) bt++;
      exp = ((bt / 2) % 2 == 1) ? 4'b0100 : 4'b0000;
      total++;
      if (blank !== exp) begin
        bad++; $display("FAIL blink_after_change: ticks=%0d blank=%b, required %b", bt, blank, exp);
      end
    end
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    total++;
    if (state !== 3'd0 || blank !== 4'b0000) begin
      bad++; $display("FAIL blink_exit: state=%0d blank=%b, required 0 0000", state, blank);
    end
  endtask

  task automatic test_timeout();
    int   bt;
    bit   ext, done, due;
    logic [2:0] exp;
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    bt = 0; ext = 1'b0; done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      due = (bt == ET);
      if (!ext && bt == 5) begin
        sb.push_back(5'b00010);
        pulse(1'b0, 1'b0, 1'b1);
        ext = 1'b1;
        bt = 0;
      end else begin
        step();
        if (!due && cyc % 5 == 0) bt++;
      end
      exp = due ? 3'd0 : 3'd2;
      total++;
      if (state !== exp) begin
        bad++; $display("FAIL timeout_state: ticks=%0d state=%0d, required %0d", bt, state, exp);
      end
      if (due) done = 1'b1;
    end
    total++;
    if (!done || blank !== 4'b0000) begin
      bad++; $display("FAIL timeout_reached: done=%b blank=%b, required 1 0000", done, blank);
    end
  endtask

  task automatic test_priority_clear();
    pulse(1'b1, 1'b1, 1'b0);
    total++;
    if (running !== 1'b1 || state !== 3'd0) begin
      bad++; $display("FAIL prio_start_set: running=%b state=%0d, required 1 0", running, state);
    end
    pulse(1'b0, 1'b1, 1'b0);
    total++;
    if (state !== 3'd0) begin
      bad++; $display("FAIL set_while_running: state=%0d, required 0", state);
    end
    pulse(1'b0, 1'b0, 1'b1);
    total++;
    if (clear !== 1'b0) begin
      bad++; $display("FAIL clear_while_running: clear=%b, required 0", clear);
    end
    pulse(1'b1, 1'b0, 1'b0);
    sb.push_back(5'b10000);
    pulse(1'b0, 1'b0, 1'b1);
    total++;
    if (clear !== 1'b1 || running !== 1'b0) begin
      bad++; $display("FAIL clear_pulse: clear=%b running=%b, required 1 0", clear, running);
    end
    step();
    total++;
    if (clear !== 1'b0) begin
      bad++; $display("FAIL clear_one_cycle: clear=%b, required 0", clear);
    end
    pulse(1'b0, 1'b1, 1'b1);
    total++;
    if (state !== 3'd1 || clear !== 1'b0 || inc !== 4'b0000) begin
      bad++; $display("FAIL prio_set_change: state=%0d clear=%b inc=%b, required 1 0 0000", state, clear, inc);
    end
    for (int j = 0; j < 4; j++) pulse(1'b0, 1'b1, 1'b0);
    total++;
    if (state !== 3'd0) begin
      bad++; $display("FAIL prio_return_idle: state=%0d, required 0", state);
    end
  endtask

  task automatic test_async_reset();
    for (int j = 0; j < 4; j++) pulse(1'b0, 1'b1, 1'b0);
    total++;
    if (state !== 3'd4) begin
      bad++; $display("FAIL ar_enter_edit3: state=%0d, required 4", state);
    end
    ch = 1'b1;
    #2; rstn = 1'b0;
    #1;
    total++;
    if ({running, tick, state, inc, clear, blank} !== 14'b0) begin
      bad++; $display("FAIL ar_immediate: got %b, required all zero", {running, tick, state, inc, clear, blank});
    end
    ch = 1'b0;
    st = 1'b1;
    @(negedge clk); #2; rstn = 1'b1;
    step();
    st = 1'b0;
    total++;
    if (state !== 3'd1 || inc !== 4'b0000 || running !== 1'b0) begin
      bad++; $display("FAIL ar_first_edge: state=%0d inc=%b running=%b, required 1 0000 0", state, inc, running);
    end
    repeat (3) step();
    total++;
    if (inc !== 4'b0000) begin
      bad++; $display("FAIL ar_no_inc: inc=%b, required 0000", inc);
    end
    for (int j = 0; j < 4; j++) pulse(1'b0, 1'b1, 1'b0);
    total++;
    if (state !== 3'd0) begin
      bad++; $display("FAIL ar_return_idle: state=%0d, required 0", state);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_edit_walk();
    test_blink();
    test_timeout();
    test_priority_clear();
    test_async_reset();
    repeat (2) step();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL strobe_missing: %0d expected strobes never seen, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
